// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, timing bundle type and totals helper
package vga_pkg;

  localparam int unsigned H_SIZE = 10;
  localparam int unsigned V_SIZE = 10;

  typedef struct packed {
    int unsigned display;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{display: 640, front: 16, sync: 96, back: 48};
  localparam vga_timing_t VGA_640X480_V = '{display: 480, front: 10, sync: 2,  back: 33};

  function automatic int unsigned timing_total(input vga_timing_t t);
    return t.display + t.front + t.sync + t.back;
  endfunction

  localparam int unsigned H_TOTAL = timing_total(VGA_640X480_H);
  localparam int unsigned V_TOTAL = timing_total(VGA_640X480_V);

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one raster axis: wrapping counter with next-state sync/active decode
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480_H,
  parameter logic        POL    = 1'b0,
  parameter int unsigned WIDTH  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int unsigned      TOTAL       = timing_total(TIMING);
  localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ACTIVE_LAST = WIDTH'(TIMING.display - 1);
  localparam logic [WIDTH-1:0] SYNC_FIRST  = WIDTH'(TIMING.display + TIMING.front);
  localparam logic [WIDTH-1:0] SYNC_LAST   = WIDTH'(TIMING.display + TIMING.front + TIMING.sync - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count; wrap is suppressed under reset so it only marks a genuine rollover
  always_comb begin
    wrap    = enable && !reset && (count_q == LAST);
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Decode sync/active from the next count so the parent's registers line up with count
  always_comb begin
    sync   = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? POL : ~POL;
    active = (count_d <= ACTIVE_LAST);
  end

  // Counter register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator; VGA_VBLANK_IRQ_EN adds the vblank_irq/vblank_ack flag
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_640X480_H.display,
  parameter int unsigned H_FRONT   = VGA_640X480_H.front,
  parameter int unsigned H_SYNC    = VGA_640X480_H.sync,
  parameter int unsigned H_BACK    = VGA_640X480_H.back,
  parameter int unsigned V_DISPLAY = VGA_640X480_V.display,
  parameter int unsigned V_FRONT   = VGA_640X480_V.front,
  parameter int unsigned V_SYNC    = VGA_640X480_V.sync,
  parameter int unsigned V_BACK    = VGA_640X480_V.back,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic              pixel_clk,
  input  logic              reset,
`ifdef VGA_VBLANK_IRQ_EN
  input  logic              vblank_ack,
  output logic              vblank_irq,
`endif
  output logic [H_SIZE-1:0] x_addr,
  output logic [V_SIZE-1:0] y_addr,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              video_on,
  output logic              frame_start
);

  localparam vga_timing_t H_TIMING = '{display: H_DISPLAY, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam vga_timing_t V_TIMING = '{display: V_DISPLAY, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  localparam int unsigned H_TOT    = timing_total(H_TIMING);
  localparam int unsigned V_TOT    = timing_total(V_TIMING);

  if (H_TOT > (32'd1 << H_SIZE)) begin : g_h_range_check
    $error("vga_sync_gen: horizontal total does not fit in x_addr");
  end
  if (V_TOT > (32'd1 << V_SIZE)) begin : g_v_range_check
    $error("vga_sync_gen: vertical total does not fit in y_addr");
  end

  logic [H_SIZE-1:0] h_count_next;
  logic [V_SIZE-1:0] v_count_next;
  logic              h_sync, v_sync, h_active, v_active, h_wrap, v_wrap;

  vga_axis_cnt #(.TIMING(H_TIMING), .POL(HSYNC_POL), .WIDTH(H_SIZE)) u_h_axis (
    .clk        (pixel_clk),
    .reset      (reset),
    .enable     (1'b1),
    .count      (x_addr),
    .count_next (h_count_next),
    .sync       (h_sync),
    .active     (h_active),
    .wrap       (h_wrap)
  );

  vga_axis_cnt #(.TIMING(V_TIMING), .POL(VSYNC_POL), .WIDTH(V_SIZE)) u_v_axis (
    .clk        (pixel_clk),
    .reset      (reset),
    .enable     (h_wrap),
    .count      (y_addr),
    .count_next (v_count_next),
    .sync       (v_sync),
    .active     (v_active),
    .wrap       (v_wrap)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic frame_start_q, frame_start_d;

  // Output decode from next-state counters; reset forces the idle levels
  always_comb begin
    hsync_d       = h_sync;
    vsync_d       = v_sync;
    video_on_d    = h_active && v_active;
    // Origin reached by a real rollover, not by the reset-forced zero
    frame_start_d = v_wrap && (h_count_next == '0) && (v_count_next == '0);
    if (reset) begin
      hsync_d       = ~HSYNC_POL;
      vsync_d       = ~VSYNC_POL;
      video_on_d    = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Output registers, aligned with x_addr/y_addr
  always_ff @(posedge pixel_clk) begin
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    video_on_q    <= video_on_d;
    frame_start_q <= frame_start_d;
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic vblank_irq_q, vblank_irq_d;

  // Sticky flag: set at the first blanking line's x=0, cleared by ack; set beats ack
  always_comb begin
    vblank_irq_d = vblank_irq_q;
    if (vblank_ack) begin
      vblank_irq_d = 1'b0;
    end
    if ((h_count_next == '0) && (v_count_next == V_SIZE'(V_DISPLAY))) begin
      vblank_irq_d = 1'b1;
    end
    if (reset) begin
      vblank_irq_d = 1'b0;
    end
  end

  // Flag register
  always_ff @(posedge pixel_clk) begin
    vblank_irq_q <= vblank_irq_d;
  end

  assign vblank_irq = vblank_irq_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen on a reduced raster
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 4, HS = 6, HB = 6;
  localparam int VD = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic [9:0] x_addr, y_addr;
  logic       vga_hsync, vga_vsync, video_on, frame_start;
`ifdef VGA_VBLANK_IRQ_EN
  logic       vblank_ack, vblank_irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  int t = 0;
  bit in_rst = 1'b1;
  bit irq_m = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
`ifdef VGA_VBLANK_IRQ_EN
    .vblank_ack (vblank_ack),
    .vblank_irq (vblank_irq),
`endif
    .x_addr     (x_addr),
    .y_addr     (y_addr),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .video_on   (video_on),
    .frame_start(frame_start)
  );

  typedef struct {
    bit rst;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit fs;
  } vec_t;

  vec_t tbl[8];

  function automatic int mx(input int tt);
    return tt % HT;
  endfunction

  function automatic int my(input int tt);
    return (tt / HT) % VT;
  endfunction

  task automatic tick(input bit rst, input bit ack);
    reset = rst;
`ifdef VGA_VBLANK_IRQ_EN
    vblank_ack = ack;
`endif
    @(posedge pixel_clk);
    #1;
    if (rst) begin
      t = 0;
      in_rst = 1'b1;
      irq_m = 1'b0;
    end else begin
      t++;
      in_rst = 1'b0;
      if (mx(t) == 0 && my(t) == VD) irq_m = 1'b1;
      else if (ack) irq_m = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    int x, y;
    bit ehs, evs, evon, efs;
    logic [23:0] got, exp;
    x = mx(t);
    y = my(t);
    ehs  = !(x >= HD + HF && x < HD + HF + HS);
    evs  = !(y >= VD + VF && y < VD + VF + VS);
    evon = !in_rst && x < HD && y < VD;
    efs  = !in_rst && x == 0 && y == 0;
    got = {x_addr, y_addr, vga_hsync, vga_vsync, video_on, frame_start};
    exp = {10'(x), 10'(y), ehs, evs, evon, efs};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
               name, t, x_addr, y_addr, vga_hsync, vga_vsync, video_on, frame_start,
               x, y, ehs, evs, evon, efs);
    end
`ifdef VGA_VBLANK_IRQ_EN
    vectors++;
    if (vblank_irq !== irq_m) begin
      miscompares++;
      $display("FAIL %s_irq t=%0d: got %b, expected %b", name, t, vblank_irq, irq_m);
    end
`endif
  endtask

  initial begin : main
    int hs_low, vs_low, von_cnt, vs_run, vs_max, found;
    int fs_times[$];
    logic [23:0] got, exp;

    tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].rst, 1'b0);
      got = {x_addr, y_addr, vga_hsync, vga_vsync, video_on, frame_start};
      exp = {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].hs, tbl[i].vs, tbl[i].von, tbl[i].fs};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL table[%0d]: got %h, expected %h", i, got, exp);
      end
    end

    hs_low = 0; vs_low = 0; von_cnt = 0; vs_run = 0; vs_max = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, 1'b0);
      check_model("run");
      if (i < FRAME) begin
        if (!vga_hsync) hs_low++;
        if (!vga_vsync) vs_low++;
        if (video_on) von_cnt++;
        if (!vga_vsync) vs_run++;
        else vs_run = 0;
        if (vs_run > vs_max) vs_max = vs_run;
      end
      if (frame_start) fs_times.push_back(i);
    end
    chk("hsync_low_per_frame", hs_low, HS * VT);
    chk("vsync_low_per_frame", vs_low, VS * HT);
    chk("vsync_run_length", vs_max, VS * HT);
    chk("video_on_per_frame", von_cnt, HD * VD);
    chk("frame_start_count", fs_times.size(), 2);
    if (fs_times.size() == 2) chk("frame_start_period", fs_times[1] - fs_times[0], FRAME);

    found = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (mx(t) == 10 && my(t) == 5) begin
        found = 1;
        break;
      end
      tick(1'b0, 1'b0);
      check_model("seek");
    end
    chk("seek_x10_y5", found, 1);
    tick(1'b1, 1'b0);
    check_model("midreset");
    chk("midreset_x", x_addr, 0);
    chk("midreset_y", y_addr, 0);
    chk("midreset_von", video_on, 0);
    tick(1'b0, 1'b0);
    check_model("resume");
    chk("resume_x", x_addr, 1);

`ifdef VGA_VBLANK_IRQ_EN
    found = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(1'b0, 1'b0);
      check_model("irq_seek");
      if (mx(t) == 0 && my(t) == VD) begin
        found = 1;
        break;
      end
    end
    chk("irq_seek", found, 1);
    chk("irq_set", vblank_irq, 1);
    tick(1'b0, 1'b0);
    chk("irq_hold", vblank_irq, 1);
    tick(1'b0, 1'b1);
    chk("irq_ack", vblank_irq, 0);
    tick(1'b0, 1'b1);
    chk("irq_ack_idle", vblank_irq, 0);
    found = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (mx(t) == HT - 1 && my(t) == VD - 1) begin
        found = 1;
        break;
      end
      tick(1'b0, 1'b0);
      check_model("irq_seek2");
    end
    chk("irq_seek2", found, 1);
    tick(1'b0, 1'b1);
    check_model("irq_set_vs_ack");
    chk("irq_set_wins", vblank_irq, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
